gate_delay_sweep: RTL and testbench
===================================

GATE_DELAY_SWEEP -- requirements
Module: gate_delay_sweep

Interface
REQ-001 Parameter SETTLE_CYC, default 8, is the number of clock cycles each input vector is held before the outputs are sampled; legal range 3..255.
REQ-002 Parameter SAT_MAX, default 255, is the saturation value of glitch_cnt.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a full 8-vector sweep; honoured only in IDLE.
REQ-006 x_in  input  1  x output of the downstream delayed-gate circuit; asynchronous to clk.
REQ-007 y_in  input  1  y output of the downstream delayed-gate circuit; asynchronous to clk.
REQ-008 abc_out  output  3  drives {A,B,C} of the circuit: A = bit2, C = bit0.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when the sweep completes.
REQ-011 tt_x  output  8  captured x truth table; bit i is the result for vector i.
REQ-012 tt_y  output  8  captured y truth table; bit i is the result for vector i.
REQ-013 glitch_cnt  output  8  count of vectors that showed a glitch, saturating.

Function
REQ-014 x_in and y_in SHALL each pass through a 2-flop synchronizer; the FSM reads only the synchronized values xs and ys.
REQ-015 The FSM SHALL have the states IDLE, DRIVE, SETTLE, SAMPLE and DONE, plus a 3-bit vector index idx.
REQ-016 IDLE with start=1 SHALL go to DRIVE, set idx=0, and clear tt_x, tt_y and glitch_cnt.
REQ-017 DRIVE SHALL last 1 cycle: abc_out<=idx, load the settle counter with SETTLE_CYC-1, clear the per-vector change counter, then go to SETTLE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, counting cycles in which xs or ys differs from its value in the previous cycle; the change counter saturates at 3.
REQ-019 SAMPLE SHALL last 1 cycle and perform three actions:
- tt_x[idx]<=xs and tt_y[idx]<=ys;
- if the change count >1, glitch_cnt<=glitch_cnt+1, saturating at SAT_MAX;
- if idx==7 go to DONE, else idx<=idx+1 and go to DRIVE.
REQ-020 DONE SHALL last 1 cycle with done=1, then go to IDLE; done is low in every other state.
REQ-021 busy SHALL be 1 in DRIVE, SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-022 start asserted while busy=1 or in DONE SHALL be ignored; it is neither queued nor allowed to restart the sweep.
REQ-023 done SHALL assert exactly 8*(SETTLE_CYC+2)+1 cycles after the cycle in which start was sampled in IDLE.
REQ-024 abc_out, tt_x, tt_y and glitch_cnt SHALL hold their values in IDLE and DONE until the next accepted start.
REQ-025 idx SHALL NOT wrap past 7; a sweep always covers vectors 0..7 in ascending order.

Reset
REQ-026 rst_n=0 SHALL immediately force the following, regardless of clk:
- state IDLE, idx=0;
- abc_out=3'b000;
- busy=0 and done=0;
- tt_x=8'h00, tt_y=8'h00, glitch_cnt=8'h00;
- both synchronizer stages cleared to 0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep; no done pulse is produced, and after release the block waits in IDLE for a new start.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the SETTLE_CYC default value and the vector-count constant (8).
REQ-029 The 2-flop synchronizer SHALL be a sub-module named sync2, instantiated once each for x_in and y_in.

Verification
REQ-030 Bench model: x=(A&B)|~C and y=~C, with internal delays of 30/10/20 ns, clk period 10 ns, SETTLE_CYC=8 -> after done, tt_x=8'hD5, tt_y=8'h55 and glitch_cnt=0.
REQ-031 Bench model: force x_in to toggle 0->1->0->1 during the vector-3 settle window -> glitch_cnt=1 and tt_x[3] equals the final forced value.
REQ-032 Latency: start pulse at cycle 0 with SETTLE_CYC=8 -> done high at cycle 81 only, and busy high for cycles 1..80.
REQ-033 Assert start again at cycle 20 of a sweep -> no restart, and done still at cycle 81.
REQ-034 Assert rst_n=0 at cycle 40 of a sweep -> same cycle abc_out=0, busy=0, tt_x=tt_y=0; no done pulse; a new start then yields a full correct sweep.
REQ-035 Force glitches on every vector over 32 sweeps with SAT_MAX=255 -> glitch_cnt counts 8 per sweep and is cleared at each accepted start; check saturation with SAT_MAX=5 -> glitch_cnt stays at 5.

Source files
------------

// File: rtl/gate_delay_sweep_pkg.sv
// Shared types and constants for the gate delay sweep controller.
package gate_delay_sweep_pkg;

    localparam int unsigned SETTLE_CYC_DEF = 8;
    localparam int unsigned NUM_VEC        = 8;
    localparam int unsigned IDX_W          = $clog2(NUM_VEC);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Per-vector change counter only needs to distinguish 0, 1 and "more than one".
    function automatic logic [1:0] chg_inc(input logic [1:0] c);
        return (c == 2'd3) ? c : c + 2'd1;
    endfunction

endpackage

// File: rtl/gate_delay_sweep_sync2.sv
// Two-flop synchronizer for one asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gate_delay_sweep.sv
// Sweeps all eight {A,B,C} vectors into a delayed-gate circuit, captures the
// settled x/y truth tables and counts vectors whose outputs glitched.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start; results held
// ST_DRIVE  | present vector idx on abc_out, arm settle timer
// ST_SETTLE | hold vector SETTLE_CYC cycles, count cycles with xs/ys change
// ST_SAMPLE | capture xs/ys into tables, bump glitch count, advance idx
// ST_DONE   | one-cycle done pulse
module gate_delay_sweep
    import gate_delay_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned SAT_MAX    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       x_in,
    input  logic       y_in,
    output logic [2:0] abc_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt_x,
    output logic [7:0] tt_y,
    output logic [7:0] glitch_cnt
);

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]       SAT_VAL     = 8'(SAT_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);

    logic xs;
    logic ys;

    sync2 u_sync_x (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (x_in),
        .q_o   (xs)
    );

    sync2 u_sync_y (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (y_in),
        .q_o   (ys)
    );

    state_e           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [2:0]       abc_q,    abc_d;
    logic [7:0]       settle_q, settle_d;
    logic [1:0]       chg_q,    chg_d;
    logic [7:0]       tt_x_q,   tt_x_d;
    logic [7:0]       tt_y_q,   tt_y_d;
    logic [7:0]       glitch_q, glitch_d;
    logic             xs_prev_q;
    logic             ys_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            abc_q     <= 3'b000;
            settle_q  <= 8'h00;
            chg_q     <= 2'd0;
            tt_x_q    <= 8'h00;
            tt_y_q    <= 8'h00;
            glitch_q  <= 8'h00;
            xs_prev_q <= 1'b0;
            ys_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            abc_q     <= abc_d;
            settle_q  <= settle_d;
            chg_q     <= chg_d;
            tt_x_q    <= tt_x_d;
            tt_y_q    <= tt_y_d;
            glitch_q  <= glitch_d;
            xs_prev_q <= xs;
            ys_prev_q <= ys;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        abc_d    = abc_q;
        settle_d = settle_q;
        chg_d    = chg_q;
        tt_x_d   = tt_x_q;
        tt_y_d   = tt_y_q;
        glitch_d = glitch_q;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    idx_d    = '0;
                    tt_x_d   = 8'h00;
                    tt_y_d   = 8'h00;
                    glitch_d = 8'h00;
                end
            end
            ST_DRIVE: begin
                busy     = 1'b1;
                abc_d    = 3'(idx_q);
                settle_d = SETTLE_LOAD;
                chg_d    = 2'd0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if ((xs != xs_prev_q) || (ys != ys_prev_q)) begin
                    chg_d = chg_inc(chg_q);
                end
                if (settle_q == 8'h00) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - 8'h01;
                end
            end
            ST_SAMPLE: begin
                busy          = 1'b1;
                tt_x_d[idx_q] = xs;
                tt_y_d[idx_q] = ys;
                if ((chg_q > 2'd1) && (glitch_q < SAT_VAL)) begin
                    glitch_d = glitch_q + 8'h01;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign abc_out    = abc_q;
    assign tt_x       = tt_x_q;
    assign tt_y       = tt_y_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_gate_delay_sweep.sv
// Bench for gate_delay_sweep: a delayed-gate circuit model drives x/y, with
// optional forced glitch patterns; two DUTs differ only in SAT_MAX.
module tb_gate_delay_sweep;

    localparam int SAT2 = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       x_in, y_in;
    logic [2:0] abc_out, abc_out2;
    logic       busy, busy2, done, done2;
    logic [7:0] tt_x, tt_y, glitch_cnt;
    logic [7:0] tt_x2, tt_y2, glitch_cnt2;

    always #5 clk = ~clk;

    gate_delay_sweep #(.SETTLE_CYC(8), .SAT_MAX(255)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
        .abc_out(abc_out), .busy(busy), .done(done),
        .tt_x(tt_x), .tt_y(tt_y), .glitch_cnt(glitch_cnt)
    );

    gate_delay_sweep #(.SETTLE_CYC(8), .SAT_MAX(SAT2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
        .abc_out(abc_out2), .busy(busy2), .done(done2),
        .tt_x(tt_x2), .tt_y(tt_y2), .glitch_cnt(glitch_cnt2)
    );

    // Circuit model: x = (A&B)|~C, y = ~C. NOT 10 ns, AND 30 ns, output stage
    // 20 ns on both x and y, plus 1 ns of routing so edges never meet clk.
    logic [2:0] abc_d = 3'b000;
    logic       ab_w = 1'b0, nc_w = 1'b1, x_gate = 1'b1, y_gate = 1'b1;
    logic       xmode = 1'b0, ymode = 1'b0, x_force = 1'b0, y_force = 1'b0;

    always begin @(abc_out); #1;  abc_d  = abc_out; end
    always begin @(abc_d);   #30; ab_w   = abc_d[2] & abc_d[1]; end
    always begin @(abc_d);   #10; nc_w   = ~abc_d[0]; end
    always begin @(ab_w or nc_w); #20; x_gate = ab_w | nc_w; end
    always begin @(nc_w);    #20; y_gate = nc_w; end

    assign x_in = xmode ? x_force : x_gate;
    assign y_in = ymode ? y_force : y_gate;

    int n_checks = 0;
    int n_fail   = 0;
    int nx[8];
    int ny[8];

    typedef struct {
        int         extra_start;
        int         glitch_vec;
        logic [7:0] ex;
        logic [7:0] ey;
        int         eg;
    } row_t;

    row_t rows[4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_tt_x();
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) r[i] = (i[2] & i[1]) | ~i[0];
        return r;
    endfunction

    function automatic logic [7:0] ref_tt_y();
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) r[i] = ~i[0];
        return r;
    endfunction

    // Entered at a negedge with the DUT idle; start is sampled at edge 0 and
    // every later negedge c sits in cycle c. Vector v drives in cycle 1+10v.
    task automatic run_sweep(input int extra_start, input int glitch_vec, input bit forced,
                             input logic [7:0] ex, input logic [7:0] ey, input int eg,
                             input string tag);
        int eg2;
        eg2 = (eg > SAT2) ? SAT2 : eg;
        start = 1'b1;
        for (int c = 1; c <= 83; c++) begin
            @(negedge clk);
            start = (c == extra_start);
            if (c == 1) begin
                check({tag, " cleared glitch_cnt"}, int'(glitch_cnt), 0);
                check({tag, " cleared tt_x"}, int'(tt_x), 0);
            end
            if (c >= 2 && c <= 81) begin
                int v, w;
                v = (c - 2) / 10;
                w = (c - 2) % 10;
                if (w == 0) begin
                    check({tag, " abc_out"}, int'(abc_out), v);
                    check({tag, " abc_out sat"}, int'(abc_out2), v);
                end
                if (forced && w < 3) begin
                    if (w < nx[v]) x_force = ~x_force;
                    if (w < ny[v]) y_force = ~y_force;
                end
                if (v == glitch_vec && w < 4) begin
                    xmode   = 1'b1;
                    x_force = w[0];
                end
            end
            if (glitch_vec >= 0 && c == 10 * glitch_vec + 17) xmode = 1'b0;
            check({tag, " busy"}, int'(busy), (c >= 1 && c <= 80) ? 1 : 0);
            check({tag, " done"}, int'(done), (c == 81) ? 1 : 0);
            check({tag, " done sat"}, int'(done2), (c == 81) ? 1 : 0);
            if (c == 81) begin
                check({tag, " tt_x"}, int'(tt_x), int'(ex));
                check({tag, " tt_y"}, int'(tt_y), int'(ey));
                check({tag, " glitch_cnt"}, int'(glitch_cnt), eg);
                check({tag, " tt_x sat"}, int'(tt_x2), int'(ex));
                check({tag, " tt_y sat"}, int'(tt_y2), int'(ey));
                check({tag, " glitch_cnt sat"}, int'(glitch_cnt2), eg2);
            end
            if (c == 83) begin
                check({tag, " abc_out hold"}, int'(abc_out), 7);
                check({tag, " tt_x hold"}, int'(tt_x), int'(ex));
                check({tag, " glitch hold"}, int'(glitch_cnt), eg);
            end
        end
        if (glitch_vec >= 0) xmode = 1'b0;
        start = 1'b0;
    endtask

    // Random toggle counts per vector; toggles of x and y share negedges, so
    // a vector's change cycles are max(nx, ny) and it glitches when that is >1.
    task automatic forced_sweep(input bit all_glitch);
        logic [7:0] ex, ey;
        logic       mx, my;
        int         g;
        mx = x_force;
        my = y_force;
        g  = 0;
        for (int v = 0; v < 8; v++) begin
            nx[v] = all_glitch ? int'($urandom_range(3, 2)) : int'($urandom_range(3, 0));
            ny[v] = int'($urandom_range(3, 0));
            if (nx[v] % 2 == 1) mx = ~mx;
            if (ny[v] % 2 == 1) my = ~my;
            ex[v] = mx;
            ey[v] = my;
            if (nx[v] > 1 || ny[v] > 1) g++;
        end
        run_sweep(0, -1, 1'b1, ex, ey, g, all_glitch ? "glitchy" : "rand");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, reached %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] rx, ry;
        bit         seen_done;
        rx = ref_tt_x();
        ry = ref_tt_y();
        rows[0] = '{0,  -1, rx,          ry, 0};
        rows[1] = '{20, -1, rx,          ry, 0};
        rows[2] = '{81,  3, rx | 8'h08,  ry, 1};
        rows[3] = '{0,   5, rx | 8'h20,  ry, 1};

        repeat (3) @(negedge clk);
        check("reset abc_out", int'(abc_out), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset tt_x", int'(tt_x), 0);
        check("reset tt_y", int'(tt_y), 0);
        check("reset glitch_cnt", int'(glitch_cnt), 0);
        check("reset glitch_cnt sat", int'(glitch_cnt2), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Reset in cycle 40 of a sweep, while vector 3 is being sampled.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset abc_out", int'(abc_out), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset tt_x", int'(tt_x), 0);
        check("midreset tt_y", int'(tt_y), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("post-reset activity", int'(seen_done), 0);

        for (int r = 0; r < 4; r++) begin
            run_sweep(rows[r].extra_start, rows[r].glitch_vec, 1'b0,
                      rows[r].ex, rows[r].ey, rows[r].eg, $sformatf("row%0d", r));
        end

        x_force = x_gate;
        y_force = y_gate;
        xmode   = 1'b1;
        ymode   = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 32; s++) forced_sweep(1'b1);
        for (int s = 0; s < 8; s++)  forced_sweep(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
